// File: rtl/fpalu_pkg.sv
// Shared FPALU / FP16 format constants and the pipeline payload types
// used by the FP29i-to-FP16 output packer.
package fpalu_pkg;
  localparam int AL_EXPSIZE = 6;
  localparam int AL_MANSIZE = 22;
  localparam int AL_EXPBIAS = 31;

  localparam int FP16_EXP  = 5;
  localparam int FP16_MAN  = 10;
  localparam int FP16_BIAS = 15;

  localparam int         REBIAS       = AL_EXPBIAS - FP16_BIAS;
  localparam logic [4:0] FP16_INF_EXP = 5'h1F;

  // Normalized word: hidden bit dropped, exponent already rebiased to FP16.
  typedef struct packed {
    logic                    sgn;
    logic                    zero;
    logic [AL_MANSIZE-2:0]   frac;
    logic signed [7:0]       exp;
  } norm_t;

  // Packed FP16 result plus the exception events it raises.
  typedef struct packed {
    logic [15:0] fp16;
    logic        ovf;
    logic        unf;
    logic        inx;
  } rnd_t;
endpackage

// File: rtl/count_lead_zero.sv
// Leading-zero counter; returns W_IN for an all-zero input.
// Purely combinational.
module count_lead_zero #(
  parameter int W_IN  = 32,
  parameter int W_OUT = $clog2(W_IN + 1)
) (
  input  logic [W_IN-1:0]  in_i,
  output logic [W_OUT-1:0] cnt_o
);
  always_comb begin
    cnt_o = W_OUT'(W_IN);
    // Ascending scan: the last hit is the most significant set bit.
    for (int i = 0; i < W_IN; i++) begin
      if (in_i[i]) cnt_o = W_OUT'(W_IN - 1 - i);
    end
  end
endmodule

// File: rtl/fp29i_to_fp16.sv
// FP29i -> IEEE FP16 packer: normalize (stage A), round-nearest-even (stage B), output register.
// Latency 2 edges after acceptance; valid/ready backpressure, sticky ovf/unf/inx flags.
module fp29i_to_fp16
  import fpalu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sgn,
  input  logic [AL_EXPSIZE-1:0] in_exp,
  input  logic [AL_MANSIZE-1:0] in_man,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_fp16,
  input  logic                  flag_clr,
  output logic                  flag_ovf,
  output logic                  flag_unf,
  output logic                  flag_inx
);
  logic [5:0]            lz32, lz;
  logic [AL_MANSIZE-1:0] man_n;
  norm_t                 norm_d, a_q;
  rnd_t                  rnd_d, b_q;
  logic                  va_q, vb_q, ov_q, va_d, vb_d, ov_d;
  logic                  a_load, b_load, o_load;
  logic [15:0]           out_q;
  logic                  ovf_q, unf_q, inx_q;

  count_lead_zero #(.W_IN(32)) u_lzd (
    .in_i  ({10'b0, in_man}),
    .cnt_o (lz32)
  );

  always_comb begin
    lz           = lz32 - 6'd10;
    man_n        = in_man << lz;
    norm_d.sgn   = in_sgn;
    norm_d.zero  = ~man_n[AL_MANSIZE-1];
    norm_d.frac  = man_n[AL_MANSIZE-2:0];
    norm_d.exp   = {2'b00, in_exp} - {2'b00, lz} - 8'(REBIAS);
  end

  logic [9:0]        kept;
  logic              guard, sticky, inc;
  logic [10:0]       sum;
  logic [7:0]        shm1;
  logic [42:0]       shv;
  logic signed [7:0] exp_f;

  always_comb begin
    kept   = a_q.frac[20:11];
    guard  = a_q.frac[10];
    sticky = |a_q.frac[9:0];
    shm1   = 8'd0 - a_q.exp;
    shv    = '0;
    if (a_q.exp < 8'sd1) begin
      // Subnormal: shifting {1,f} right by (1-e) equals shifting {1,f,21'b0} by -e.
      if (shm1 > 8'd21) begin
        kept   = '0;
        guard  = 1'b0;
        sticky = 1'b1;
      end else begin
        shv    = {1'b1, a_q.frac, 21'b0} >> shm1[4:0];
        kept   = shv[42:33];
        guard  = shv[32];
        sticky = |shv[31:0];
      end
    end
    inc   = guard & (sticky | kept[0]);
    sum   = {1'b0, kept} + {10'b0, inc};
    exp_f = (a_q.exp < 8'sd1) ? {7'b0, sum[10]} : a_q.exp + {7'b0, sum[10]};

    rnd_d = '0;
    if (a_q.zero) begin
      rnd_d.fp16 = {a_q.sgn, 15'b0};
    end else if (exp_f >= 8'sd31) begin
      rnd_d.fp16 = {a_q.sgn, FP16_INF_EXP, 10'b0};
      rnd_d.ovf  = 1'b1;
      rnd_d.inx  = 1'b1;
    end else begin
      rnd_d.fp16 = {a_q.sgn, exp_f[4:0], sum[9:0]};
      rnd_d.inx  = guard | sticky;
      rnd_d.unf  = (exp_f == 8'sd0) & (guard | sticky);
    end
  end

  always_comb begin
    in_ready = ~va_q | ~vb_q | out_ready;
    o_load   = vb_q & (~ov_q | out_ready);
    b_load   = va_q & (~vb_q | o_load);
    a_load   = in_valid & in_ready;
    va_d     = a_load | (va_q & ~b_load);
    vb_d     = b_load | (vb_q & ~o_load);
    ov_d     = o_load | (ov_q & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q  <= 1'b0;
      vb_q  <= 1'b0;
      ov_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
      ov_q <= ov_d;
      if (a_load) a_q <= norm_d;
      if (b_load) b_q <= rnd_d;
      if (o_load) out_q <= b_q.fp16;
      // A set event in the clearing cycle still lands.
      ovf_q <= (ovf_q & ~flag_clr) | (o_load & b_q.ovf);
      unf_q <= (unf_q & ~flag_clr) | (o_load & b_q.unf);
      inx_q <= (inx_q & ~flag_clr) | (o_load & b_q.inx);
    end
  end

  assign out_valid = ov_q;
  assign out_fp16  = out_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign flag_inx  = inx_q;
endmodule

// File: tb/tb_fp29i_to_fp16.sv
// Directed bench for fp29i_to_fp16: table of hand-computed conversions,
// then backpressure, mid-flight reset and flag-clear collision sequences.
module tb_fp29i_to_fp16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sgn = 1'b0;
  logic [5:0]  in_exp = '0;
  logic [21:0] in_man = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_fp16;
  logic        flag_clr = 1'b0;
  logic        flag_ovf, flag_unf, flag_inx;

  int checks = 0;
  int errors = 0;

  fp29i_to_fp16 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sgn(in_sgn), .in_exp(in_exp), .in_man(in_man),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp16(out_fp16),
    .flag_clr(flag_clr), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [5:0]  exp;
    logic [21:0] man;
    logic [15:0] res;
    logic [2:0]  flg;   // {ovf, unf, inx}
  } vec_t;

  localparam int NV = 14;
  vec_t v[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic send(input vec_t w);
    in_sgn   = w.sgn;
    in_exp   = w.exp;
    in_man   = w.man;
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    chk("accept", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp[4];
    int sent;
    int seen;
    logic [15:0] got[$];

    v[0]  = '{1'b0, 6'd31, 22'h200000, 16'h3C00, 3'b000};
    v[1]  = '{1'b0, 6'd32, 22'h100000, 16'h3C00, 3'b000};
    v[2]  = '{1'b0, 6'd31, 22'h200400, 16'h3C00, 3'b001};
    v[3]  = '{1'b0, 6'd31, 22'h200C00, 16'h3C02, 3'b001};
    v[4]  = '{1'b1, 6'd47, 22'h200000, 16'hFC00, 3'b101};
    v[5]  = '{1'b0, 6'd46, 22'h3FFFFF, 16'h7C00, 3'b101};
    v[6]  = '{1'b0, 6'd16, 22'h200000, 16'h0200, 3'b000};
    v[7]  = '{1'b0, 6'd7,  22'h200000, 16'h0001, 3'b000};
    v[8]  = '{1'b0, 6'd6,  22'h200000, 16'h0000, 3'b011};
    v[9]  = '{1'b1, 6'd31, 22'h000000, 16'h8000, 3'b000};
    v[10] = '{1'b0, 6'd16, 22'h3FFFFF, 16'h0400, 3'b001};
    v[11] = '{1'b0, 6'd46, 22'h3FF800, 16'h7BFF, 3'b000};
    v[12] = '{1'b0, 6'd0,  22'h000001, 16'h0000, 3'b011};
    v[13] = '{1'b1, 6'd17, 22'h200000, 16'h8400, 3'b000};

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_fp16", out_fp16, 16'h0000);
    chk("rst_flags", {flag_ovf, flag_unf, flag_inx}, 3'b000);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Table-driven conversions with latency check
    for (int i = 0; i < NV; i++) begin
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      send(v[i]);
      tick();
      chk($sformatf("vec%0d_lat1", i), out_valid, 1'b0);
      tick();
      chk($sformatf("vec%0d_lat2", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_res", i), out_fp16, v[i].res);
      chk($sformatf("vec%0d_flags", i), {flag_ovf, flag_unf, flag_inx}, v[i].flg);
    end
    tick();

    // Backpressure: output stalled for 5 cycles while 4 words are offered
    bp = '{0, 3, 6, 7};
    sent = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 5);
      if (sent < 4) begin
        in_sgn = v[bp[sent]].sgn;
        in_exp = v[bp[sent]].exp;
        in_man = v[bp[sent]].man;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) chk("bp_ready_full2", in_ready, 1'b0);
      if (cyc == 4) begin
        chk("bp_ready_full4", in_ready, 1'b0);
        chk("bp_held_count", sent, 3);
      end
      if (out_valid && !out_ready) chk($sformatf("bp_hold_c%0d", cyc), out_fp16, v[bp[0]].res);
      if (out_valid && out_ready) got.push_back(out_fp16);
      begin
        logic acc;
        acc = in_valid & in_ready;
        tick();
        if (acc) sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_out_count", got.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < got.size()) chk($sformatf("bp_order%0d", j), got[j], v[bp[j]].res);
    end

    // Reset with two words in flight; flags are set before
    send(v[2]);
    tick(); tick(); tick();
    chk("pre_rst_inx", flag_inx, 1'b1);
    in_sgn = v[0].sgn; in_exp = v[0].exp; in_man = v[0].man; in_valid = 1'b1;
    tick();
    in_sgn = v[3].sgn; in_exp = v[3].exp; in_man = v[3].man;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_flags", {flag_ovf, flag_unf, flag_inx}, 3'b000);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mrst_no_stale", seen, 0);

    // flag_clr colliding with an overflow result: set wins, then clear works
    send(v[4]);
    tick();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("clr_coll_valid", out_valid, 1'b1);
    chk("clr_coll_ovf", flag_ovf, 1'b1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("clr_after_ovf", flag_ovf, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp29i_to_fp16.md
# fp29i_to_fp16

Output packer that sits directly downstream of the FPALU in the W4823 FIR datapath. It consumes FP29i results (1 sign, 6-bit exponent, 22-bit explicit-leading-bit mantissa) and produces IEEE-754 FP16 words. The block re-normalizes the mantissa, rebiases the exponent, and rounds to nearest-even. It handles overflow to infinity and underflow to subnormal or zero. Data moves through a 2-stage valid/ready pipeline with sticky exception flags.

## Interface
Parameters:
- none; all widths come from the shared package.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low; one clock domain.
- in_valid  in  1  the FP29i word on in_* is valid.
- in_ready  out  1  the block accepts the word this cycle when in_valid=1.
- in_sgn  in  1  FP29i sign.
- in_exp  in  6  FP29i exponent, bias 31.
- in_man  in  22  FP29i mantissa. Value = in_man/2^21 · 2^(in_exp−31). Bit 21 is not guaranteed to be set.
- out_valid  out  1  out_fp16 holds a result.
- out_ready  in  1  downstream accepts the result this cycle.
- out_fp16  out  16  IEEE FP16 result.
- flag_clr  in  1  synchronous clear of all sticky flags.
- flag_ovf  out  1  sticky; set when a result overflowed to ±inf.
- flag_unf  out  1  sticky; set when a result was tiny and inexact (subnormal or zero).
- flag_inx  out  1  sticky; set when any result was rounded.

## Operation
- Zero: in_man==0 → out_fp16 = {in_sgn,15'b0}. No flags are set.
- Stage A (normalize):
  - lz = leading-zero count of in_man (0..21).
  - m = in_man<<lz.
  - e = in_exp − lz − 16, computed as a signed 8-bit value in the range −37..47.
- Stage B (round and pack), with f = m[20:0]:
  - Normal case, e ≥ 1: kept fraction is f[20:11]; guard = f[10]; sticky = |f[9:0].
  - Subnormal case, e ≤ 0: sh = 1 − e. Shift {1,f} right by sh, ORing all shifted-out bits into sticky. Take kept = shifted[20:11] and guard = shifted[10]. If sh > 22, kept=0, guard=0 and sticky=1.
  - RNE: increment when guard & (sticky | kept LSB).
  - Fraction carry: promotes the exponent by one; a subnormal becomes the minimum normal.
  - Exponent field: e for normals, 0 for subnormals.
  - Overflow: if the final exponent is ≥ 31 → {sgn,5'h1F,10'h0}, with flag_ovf and flag_inx set.
- Flags:
  - flag_inx is set when guard|sticky.
  - flag_unf is set when the result is subnormal or zero (from a nonzero input) AND inexact.
  - Flags update only when a result is written into the output register.
  - If flag_clr and a set event occur in the same cycle, the set wins.
- No NaN is ever produced; the FP29i format has no NaN encoding.

## Timing
- Reset values:
  - out_valid=0.
  - out_fp16=16'h0000.
  - all flags 0.
  - both stage valid bits 0.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+2, provided out_ready was not holding the pipe.
- Throughput: one word per cycle.
- in_ready = ~vA | ~vB | out_ready. This is combinational from out_ready; there is no comb path from in_valid.
- Each stage advances when the stage after it is empty or is advancing.
- While out_valid=1 & out_ready=0, out_fp16 is held stable.
- Bubbles collapse: an empty stage B accepts from stage A even while the output stalls, as long as the output register is empty.
- Reset asserted mid-operation discards all in-flight words; after rst_n releases, in_ready=1 on the first cycle.

## Structure
- Shared package fpalu_pkg holds:
  - AL_EXPSIZE=6, AL_MANSIZE=22, AL_EXPBIAS=31.
  - FP16 constants: EXP=5, MAN=10, BIAS=15.
  - REBIAS=16, FP16_INF_EXP=5'h1F.
- One sub-module: count_lead_zero (the existing LZD, instantiated with W_IN=32, input left-padded) in stage A.
- The right shifter with sticky collection stays inline.

## Test plan
- exp=31, man=22'h200000, sgn=0 → 16'h3C00, no flags. With exp=32, man=22'h100000 → 16'h3C00 (renormalization).
- Rounding:
  - man=22'h200400, exp=31 → 16'h3C00 (tie to even), flag_inx=1.
  - man=22'h200C00 → 16'h3C02.
- Overflow:
  - sgn=1, exp=47, man=22'h200000 → 16'hFC00, flag_ovf=1.
  - exp=46, man=22'h3FFFFF → 16'h7C00 (rounding carry overflow).
- Subnormal and zero:
  - exp=16, man=22'h200000 → 16'h0200.
  - exp=7 → 16'h0001.
  - exp=6 → 16'h0000 with flag_unf=1.
  - man=0, sgn=1 → 16'h8000, no flags.
- Backpressure: hold out_ready=0 for 5 cycles while offering 4 words. Require:
  - in_ready drops after the pipe fills (3 words held).
  - No word is lost or duplicated; order is preserved.
  - out_fp16 is stable while stalled.
- Reset and flags:
  - Assert rst_n=0 with 2 words in flight → out_valid=0 and flags clear, and no stale word emerges afterward.
  - flag_clr in the same cycle as an overflow result → flag_ovf=1.
